// File: rtl/seg4_display_drv.sv
// Four-digit multiplexed 7-segment driver for two 0..99 binary pairs.
// Converts each pair to BCD serially, then scans the digits continuously.
module seg4_display_drv #(
    parameter int SCAN_DIV = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] val_lo,
    input  logic [6:0] val_hi,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       busy,
    output logic       ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        UPD  = 2'd2
    } state_t;

    localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

    state_t      state_q, state_d;
    logic [13:0] cap_q, cap_d;
    logic        ovf_q, ovf_d;
    logic [2:0]  step_q, step_d;
    logic [14:0] sh_lo_q, sh_lo_d;
    logic [14:0] sh_hi_q, sh_hi_d;
    logic [3:0]  d0_q, d0_d;
    logic [3:0]  d1_q, d1_d;
    logic [3:0]  d2_q, d2_d;
    logic [3:0]  d3_q, d3_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic [3:0]  cur_dig;

    // One double-dabble step on {tens, ones, binary}: adjust, then shift.
    function automatic logic [14:0] dd_step(input logic [14:0] v);
        logic [14:0] t;
        t = v;
        if (t[10:7] >= 4'd5) t[10:7] = t[10:7] + 4'd3;
        if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
        return {t[13:0], 1'b0};
    endfunction

    // Out-of-range pair values display as 99.
    function automatic logic [6:0] clamp99(input logic [6:0] v);
        return (v > 7'd99) ? 7'd99 : v;
    endfunction

    // Active-low gfedcba encoding; non-decimal codes blank the digit.
    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Converter FSM: capture on change, 7 shift steps, then publish digits.
    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        ovf_d   = ovf_q;
        step_d  = step_q;
        sh_lo_d = sh_lo_q;
        sh_hi_d = sh_hi_q;
        d0_d    = d0_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        d3_d    = d3_q;
        unique case (state_q)
            IDLE: begin
                if ({val_hi, val_lo} != cap_q) begin
                    cap_d   = {val_hi, val_lo};
                    ovf_d   = (val_hi > 7'd99) | (val_lo > 7'd99);
                    step_d  = 3'd0;
                    sh_lo_d = {8'd0, clamp99(val_lo)};
                    sh_hi_d = {8'd0, clamp99(val_hi)};
                    state_d = CONV;
                end
            end
            CONV: begin
                sh_lo_d = dd_step(sh_lo_q);
                sh_hi_d = dd_step(sh_hi_q);
                step_d  = step_q + 3'd1;
                if (step_q == 3'd6) state_d = UPD;
            end
            UPD: begin
                d0_d    = sh_lo_q[10:7];
                d1_d    = sh_lo_q[14:11];
                d2_d    = sh_hi_q[10:7];
                d3_d    = sh_hi_q[14:11];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Free-running scan: divider, digit index and registered pin drives.
    always_comb begin
        cnt_d = cnt_q + 16'd1;
        idx_d = idx_q;
        if (cnt_q >= SCAN_LAST) begin
            cnt_d = 16'd0;
            idx_d = idx_q + 2'd1;
        end
        unique case (idx_q)
            2'd0: begin cur_dig = d0_q; an_d = 4'b1110; end
            2'd1: begin cur_dig = d1_q; an_d = 4'b1101; end
            2'd2: begin cur_dig = d2_q; an_d = 4'b1011; end
            default: begin cur_dig = d3_q; an_d = 4'b0111; end
        endcase
        seg_d = enc(cur_dig);
        dp_d  = (idx_q != 2'd2);
    end

    // State register; reset wins over capture, conversion and scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cap_q   <= 14'd0;
            ovf_q   <= 1'b0;
            step_q  <= 3'd0;
            sh_lo_q <= 15'd0;
            sh_hi_q <= 15'd0;
            d0_q    <= 4'd0;
            d1_q    <= 4'd0;
            d2_q    <= 4'd0;
            d3_q    <= 4'd0;
            cnt_q   <= 16'd0;
            idx_q   <= 2'd0;
            an_q    <= 4'b1110;
            seg_q   <= 7'b1000000;
            dp_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            ovf_q   <= ovf_d;
            step_q  <= step_d;
            sh_lo_q <= sh_lo_d;
            sh_hi_q <= sh_hi_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            d3_q    <= d3_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign dp   = dp_q;
    assign ovf  = ovf_q;
    assign busy = (state_q != IDLE);

endmodule

// File: doc/seg4_display_drv.md
SEG4_DISPLAY_DRV -- requirements
Module: seg4_display_drv

Interface
REQ-001 Parameter SCAN_DIV, default 50, meaning clk cycles each digit is driven; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 val_lo  input  7  right-hand pair value (seconds-style counter output), binary, 0..99 valid.
REQ-005 val_hi  input  7  left-hand pair value (minutes-style counter output), binary, 0..99 valid.
REQ-006 seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-007 an  output  4  digit anodes, active-low one-hot, registered; an[0] is the rightmost digit.
REQ-008 dp  output  1  decimal point, active-low, registered.
REQ-009 busy  output  1  high while a conversion is in progress.
REQ-010 ovf  output  1  high when the last captured pair held a value >99.

Function
REQ-011 The block SHALL hold capture register cap = {val_hi, val_lo} (14 bits) and four 4-bit digit registers d0..d3.
REQ-012 Converter FSM states SHALL be IDLE, CONV and UPD; busy = (state != IDLE).
REQ-013 In IDLE, if {val_hi, val_lo} != cap at a clk edge: cap <= inputs, ovf <= (val_hi>99)|(val_lo>99), step <= 0, state <= CONV; otherwise stay in IDLE.
REQ-014 Any captured value >99 SHALL be converted as 99; cap stores the raw inputs.
REQ-015 CONV SHALL perform one shift-add-3 (double-dabble) step per edge on both values in parallel, 7 steps total (step 0..6), then state <= UPD.
REQ-016 UPD SHALL write d0 = lo ones, d1 = lo tens, d2 = hi ones, d3 = hi tens in one edge, then state <= IDLE.
REQ-017 Latency: digits SHALL change on the 9th edge counting the capture edge as edge 1; busy is high for exactly 8 cycles.
REQ-018 Input changes during CONV/UPD SHALL be ignored; the first IDLE cycle re-compares and recaptures if the inputs differ.
REQ-019 Scan divider: 16-bit counter 0..SCAN_DIV-1, wrapping to 0; on the wrap edge, digit index (2 bits) advances 0->1->2->3->0.
REQ-020 an SHALL be registered from the index: 0->1110, 1->1101, 2->1011, 3->0111.
REQ-021 seg SHALL be registered from the digit d[index], one cycle after the index changes, so it stays aligned with an.
REQ-022 Digit encoding (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; codes 10-15 SHALL give 1111111 (blank).
REQ-023 dp SHALL be 0 while the index is 2 (separator between pairs) and 1 otherwise.
REQ-024 When a UPD and a scan wrap occur on the same edge, seg SHALL reflect the new digit value no later than the following edge.
REQ-025 The scan SHALL run continuously and independently of the converter state.

Reset
REQ-026 When rst=1 at an edge: state=IDLE, cap=0, d0..d3=0, step=0, scan counter=0, index=0, an=1110, seg=1000000, dp=1, busy=0, ovf=0.
REQ-027 rst SHALL abort a conversion in progress; the digits are not updated from the aborted conversion.
REQ-028 rst SHALL take priority over every other event on the same edge.

Verification
REQ-029 Reset, inputs 0/0, SCAN_DIV=4 -> no busy pulse; an cycles 1110,1101,1011,0111 every 4 cycles; seg=1000000 throughout; dp=0 only while an=1011.
REQ-030 val_hi=12, val_lo=59 after reset -> busy high 8 cycles; then d0..d3 = 9,5,2,1; seg=0010000 while an=1110 and seg=1111001 while an=0111.
REQ-031 val_lo changes 59->0 on the 3rd cycle of a conversion -> the first conversion completes with 59; the next IDLE recaptures and the display shows 00 after a second 8-cycle busy.
REQ-032 val_lo=120 -> ovf=1; displayed lo pair is 99; later val_lo=7 -> ovf=0 and the display shows 07.
REQ-033 rst asserted during the 5th CONV cycle -> next edge gives busy=0, all digits 0, seg=1000000, an=1110.
REQ-034 Free-running 0..59 counter on val_lo for 120 values -> after each conversion completes, the displayed pair equals the BCD of the captured value; no an value other than the four legal codes ever appears.
